// File: rtl/titan_core_interface.sv
// Maps an address window of the shared Titan comms bus onto one core's
// input registers (writable) and result words (read-only).
module titan_core_interface #(
  parameter int START_ADDRESS = 0,
  parameter int END_ADDRESS   = 2,
  parameter int TOTAL_INPUTS  = 2,
  parameter int TOTAL_OUTPUTS = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [7:0]                  instruction,
  input  logic [23:0]                 address,
  input  logic [31:0]                 value,
  output logic [31:0]                 output_value,
  output logic                        enable,
  output logic [32*TOTAL_INPUTS-1:0]  core_inputs,
  input  logic [32*TOTAL_OUTPUTS-1:0] core_outputs
);

  // TitanComms opcodes; anything else behaves as NOP
  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;

  localparam logic [23:0] WINDOW_SPAN = 24'(END_ADDRESS - START_ADDRESS);

  logic [24:0] offset;
  logic [23:0] idx;
  logic        is_read;
  logic        is_write;
  logic [31:0] read_data;
  logic [31:0] input_regs [TOTAL_INPUTS];

  // A borrow out of the subtraction means address is below the window
  assign offset   = {1'b0, address} - 25'(START_ADDRESS);
  assign idx      = offset[23:0];
  assign enable   = ~offset[24] && (idx <= WINDOW_SPAN);
  assign is_read  = enable && (instruction == OP_READ);
  assign is_write = enable && (instruction == OP_WRITE) && (instruction != OP_NOP);

  always_comb begin
    read_data = '0;
    for (int i = 0; i < TOTAL_INPUTS; i++) begin
      if (idx == 24'(i)) read_data = input_regs[i];
    end
    for (int j = 0; j < TOTAL_OUTPUTS; j++) begin
      if (idx == 24'(TOTAL_INPUTS + j)) read_data = core_outputs[32*j +: 32];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TOTAL_INPUTS; i++) input_regs[i] <= '0;
    end else begin
      for (int i = 0; i < TOTAL_INPUTS; i++) begin
        if (is_write && (idx == 24'(i))) input_regs[i] <= value;
      end
    end
  end

  // Zero whenever not serving a read so instance outputs can be OR-combined
  always_ff @(posedge clock or posedge reset) begin
    if (reset) output_value <= '0;
    else       output_value <= is_read ? read_data : 32'd0;
  end

  always_comb begin
    core_inputs = '0;
    for (int i = 0; i < TOTAL_INPUTS; i++) core_inputs[32*i +: 32] = input_regs[i];
  end

endmodule

// File: tb/tb_titan_core_interface.sv
// Directed bench for titan_core_interface with an adder loop-back core.
module tb_titan_core_interface;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  instruction;
  logic [23:0] address;
  logic [31:0] value;
  logic [31:0] output_value;
  logic        enable;
  logic [63:0] core_inputs;
  logic [31:0] core_outputs;

  int checkCount = 0;
  int errorCount = 0;

  titan_core_interface dut (
    .clock        (clock),
    .reset        (reset),
    .instruction  (instruction),
    .address      (address),
    .value        (value),
    .output_value (output_value),
    .enable       (enable),
    .core_inputs  (core_inputs),
    .core_outputs (core_outputs)
  );

  always #5 clock = ~clock;

  // Loop-back core: result is the sum of the two input words
  assign core_outputs = core_inputs[31:0] + core_inputs[63:32];

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive at the falling edge, then return 1ns after the next rising edge
  task automatic applyStimulus(input logic [7:0] op, input logic [23:0] addr, input logic [31:0] val);
    @(negedge clock);
    instruction = op;
    address     = addr;
    value       = val;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    instruction = OP_NOP;
    address     = 24'd0;
    value       = 32'd0;
    #3;
    checkOutput("enable_in_reset", 64'(enable), 64'd1);
    checkOutput("out_in_reset", 64'(output_value), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    applyStimulus(OP_NOP, 24'd0, 32'd0);
    checkOutput("reset_out", 64'(output_value), 64'd0);
    checkOutput("reset_cin", core_inputs, 64'd0);
    checkOutput("reset_enable", 64'(enable), 64'd1);

    applyStimulus(OP_WRITE, 24'd0, 32'd7);
    checkOutput("write0", core_inputs, {32'd0, 32'd7});
    applyStimulus(OP_WRITE, 24'd1, 32'd3);
    checkOutput("write1", core_inputs, {32'd3, 32'd7});
    checkOutput("loopback", 64'(core_outputs), 64'd10);

    applyStimulus(OP_READ, 24'd2, 32'd0);
    checkOutput("read_result", 64'(output_value), 64'd10);
    applyStimulus(OP_READ, 24'd0, 32'd0);
    checkOutput("read_in0", 64'(output_value), 64'd7);
    applyStimulus(OP_READ, 24'd0, 32'd0);
    checkOutput("read_in0_held", 64'(output_value), 64'd7);
    applyStimulus(OP_READ, 24'd1, 32'd0);
    checkOutput("read_in1", 64'(output_value), 64'd3);

    applyStimulus(OP_READ, 24'd3, 32'd0);
    checkOutput("outside_enable", 64'(enable), 64'd0);
    checkOutput("outside_read", 64'(output_value), 64'd0);
    applyStimulus(OP_WRITE, 24'd3, 32'd9);
    checkOutput("outside_write", core_inputs, {32'd3, 32'd7});

    applyStimulus(OP_WRITE, 24'd2, 32'd5);
    checkOutput("write_outword", core_inputs, {32'd3, 32'd7});
    applyStimulus(OP_READ, 24'd2, 32'd0);
    checkOutput("read_after_outwrite", 64'(output_value), 64'd10);
    applyStimulus(OP_NOP, 24'd2, 32'd0);
    checkOutput("nop_clears_out", 64'(output_value), 64'd0);

    applyStimulus(8'hFF, 24'd0, 32'd99);
    checkOutput("unknown_op_cin", core_inputs, {32'd3, 32'd7});
    checkOutput("unknown_op_out", 64'(output_value), 64'd0);

    applyStimulus(OP_WRITE, 24'd1, 32'd4);
    applyStimulus(OP_WRITE, 24'd1, 32'd6);
    checkOutput("back_to_back", core_inputs, {32'd6, 32'd7});
    applyStimulus(OP_READ, 24'd2, 32'd0);
    checkOutput("read_sum2", 64'(output_value), 64'd13);

    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset_cin", core_inputs, 64'd0);
    checkOutput("midreset_out", 64'(output_value), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(OP_WRITE, 24'd0, 32'd5);
    checkOutput("write_after_reset", core_inputs, {32'd0, 32'd5});
    applyStimulus(OP_READ, 24'd0, 32'd0);
    checkOutput("read_after_reset", 64'(output_value), 64'd5);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
